// File: rtl/sdcard_ram_mover.sv
// Purpose: Avalon-MM master moving SD sector data between a byte stream and the 32-bit SD card RAM.
// Latency: the 4th byte accepted at cycle N gives avm_write at N+1; avm_read at t gives out_valid at t+2.
// Backpressure: in_ready drops during the write strobe; out_valid/out_data hold until out_ready; no prefetch.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/ready/dir/addr/len command handshake (dir 0 = stream->RAM, len 0 = 2^LEN_W words)
//   abort                        drops the active transfer, reported through err
//   in_data/in_valid/in_ready    byte sink from the SD engine
//   out_data/out_valid/out_ready byte source toward the SD engine
//   avm_*                        Avalon-MM master toward the RAM (read latency 1, no waitrequest)
//   busy, done, err              status: not idle, normal completion pulse, reject/abort pulse
module sdcard_ram_mover #(
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 51200,
    parameter int LEN_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_COLLECT,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_SEND,
        S_DONE
    } state_t;

    localparam logic [LEN_W:0]  FULL_LEN  = {1'b1, {LEN_W{1'b0}}};
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W:0]    cnt_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       shreg_q;
    logic              err_q;
    logic              abort_pend_q;

    logic [LEN_W:0]    eff_len;
    logic [ADDR_W:0]   end_addr;
    logic              range_bad;
    logic              cmd_accept;
    logic              range_rej;
    logic              eff_abort;
    logic              abort_take;
    logic              last_word;
    logic              last_byte;
    logic              issue_cycle;

    // Range check is done one bit wider than the address so the sum cannot wrap.
    assign eff_len    = (cmd_len == '0) ? FULL_LEN : {1'b0, cmd_len};
    assign end_addr   = {1'b0, cmd_addr} + (ADDR_W + 1)'(eff_len);
    assign range_bad  = end_addr > MEM_LIMIT;
    assign cmd_accept = (state_q == S_IDLE) && cmd_valid && !range_bad;
    assign range_rej  = (state_q == S_IDLE) && cmd_valid && range_bad;

    assign last_word   = cnt_q == (LEN_W + 1)'(1);
    assign last_byte   = byte_idx_q == 2'd3;
    assign issue_cycle = (state_q == S_WR_ISSUE) || (state_q == S_RD_ISSUE);

    // An abort seen during a bus strobe is held for one cycle so the strobe completes first.
    assign eff_abort = abort || abort_pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        avm_write  = 1'b0;
        avm_read   = 1'b0;
        done       = 1'b0;
        abort_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    state_d = cmd_dir ? S_RD_ISSUE : S_WR_COLLECT;
                end
            end
            S_WR_COLLECT: begin
                if (eff_abort) begin
                    abort_take = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid && last_byte) begin
                        state_d = S_WR_ISSUE;
                    end
                end
            end
            S_WR_ISSUE: begin
                avm_write = 1'b1;
                state_d   = last_word ? S_DONE : S_WR_COLLECT;
            end
            S_RD_ISSUE: begin
                avm_read = 1'b1;
                state_d  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (eff_abort) begin
                    abort_take = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_RD_SEND;
                end
            end
            S_RD_SEND: begin
                if (eff_abort) begin
                    abort_take = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready && last_byte) begin
                        state_d = last_word ? S_DONE : S_RD_ISSUE;
                    end
                end
            end
            S_DONE: begin
                // An abort landing on the completion cycle still wins over done.
                if (eff_abort) begin
                    abort_take = 1'b1;
                end else begin
                    done = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            byte_idx_q   <= '0;
            shreg_q      <= '0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            err_q        <= range_rej || abort_take;
            abort_pend_q <= issue_cycle && abort;
            if (cmd_accept) begin
                addr_q     <= cmd_addr;
                cnt_q      <= eff_len;
                byte_idx_q <= '0;
                shreg_q    <= '0;
            end else if (abort_take) begin
                byte_idx_q <= '0;
                shreg_q    <= '0;
            end else begin
                case (state_q)
                    S_WR_COLLECT: begin
                        if (in_valid && in_ready) begin
                            shreg_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                    S_WR_ISSUE: begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - (LEN_W + 1)'(1);
                    end
                    S_RD_WAIT: begin
                        shreg_q    <= avm_readdata;
                        byte_idx_q <= '0;
                    end
                    S_RD_SEND: begin
                        // Byte 0 sits in the low lane; shifting right presents the next one.
                        if (out_valid && out_ready) begin
                            shreg_q    <= {8'h00, shreg_q[31:8]};
                            byte_idx_q <= byte_idx_q + 2'd1;
                            if (last_byte) begin
                                addr_q <= addr_q + ADDR_W'(1);
                                cnt_q  <= cnt_q - (LEN_W + 1)'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign cmd_ready      = state_q == S_IDLE;
    assign busy           = state_q != S_IDLE;
    assign err            = err_q;
    assign avm_byteenable = 4'hF;
    assign avm_chipselect = avm_write || avm_read;
    assign avm_address    = avm_chipselect ? addr_q : '0;
    assign avm_writedata  = avm_write ? shreg_q : '0;
    assign out_data       = out_valid ? shreg_q[7:0] : 8'h00;

endmodule
